// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared definitions for the RV32I data memory stage:
//   - funct3 width/sign codes for loads and stores
//   - byte-lane strobe width of one 32-bit memory word
//   - access-size decode helper used by the strobe and alignment logic
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Undefined codes (011, 110, 111) fall into the word case on purpose.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_BYTE;
      F3_H, F3_HU: f3_size = SZ_HALF;
      default:     f3_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
// Combinational load formatter: picks the addressed byte or halfword out of
// the raw memory word and sign- or zero-extends it according to funct3.
// Ports:
//   word_i   [31:0] raw word read from the array
//   funct3_i [2:0]  registered load funct3
//   lo_i     [1:0]  registered byte offset within the word
//   data_o   [31:0] extended load data
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // Halfwords only ever use the upper or lower half; lo_i[0] is ignored.
    half_sel = lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_stage.sv
// data_memory_stage
// Single-port word-organised data memory for RV32I loads/stores with
// valid/ready handshakes on request and response. Loads return one cycle
// after acceptance; the response is held until rsp_ready is seen high.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned halfword/word
// accesses flagged with rsp_err and suppressed). Without it, low address
// bits are forced aligned and rsp_err is tied to 0.
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready, req_write, req_funct3, req_addr, req_wdata
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
module data_memory_stage
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  logic                        accept;
  logic [AW-1:0]               idx;
  size_e                       size;
  logic                        misaligned;
  logic [STRB_W-1:0]           strb;
  logic [STRB_W-1:0]           wen_strb;
  logic [STRB_W-1:0][7:0]      lane_wdata;
  logic                        addr_hi_unused;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_word_q;

  logic        rsp_valid_q, rsp_valid_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] load_data;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  // Upper address bits are ignored so addresses wrap modulo DEPTH*4.
  assign idx            = req_addr[AW+1:2];
  assign addr_hi_unused = ^req_addr[31:AW+2];
  assign size           = f3_size(req_funct3);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size == SZ_HALF) && req_addr[0]) ||
                      ((size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Per-lane strobe and lane data. Stores arrive LSB-aligned, so a byte is
  // replicated to every lane and a halfword to both halves; the strobe then
  // selects which lanes actually get written.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign strb[gi] = (size == SZ_BYTE) ? (req_addr[1:0] == LANE) :
                        (size == SZ_HALF) ? (req_addr[1] == LANE[1]) :
                                            1'b1;
      assign lane_wdata[gi] = (size == SZ_BYTE) ? req_wdata[7:0] :
                              (size == SZ_HALF) ? req_wdata[8*(gi%2) +: 8] :
                                                  req_wdata[8*gi +: 8];
    end
  endgenerate

  assign wen_strb = strb & {STRB_W{!misaligned}};

  // Single-port array: one access per accepted request, write or read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_write) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wen_strb[i]) begin
            mem_q[idx][8*i +: 8] <= lane_wdata[i];
          end
        end
      end else begin
        rd_word_q <= mem_q[idx];
      end
    end
  end

  // Response bookkeeping. A new accept reloads the register even when the
  // old response is consumed in the same cycle, so there is no bubble.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    write_d     = write_q;
    err_d       = err_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      write_d     = req_write;
      err_d       = misaligned;
      f3_d        = req_funct3;
      lo_d        = req_addr[1:0];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= 3'b000;
      lo_q        <= 2'b00;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      err_q       <= err_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
    end
  end

  mem_load_align u_align (
    .word_i   (rd_word_q),
    .funct3_i (f3_q),
    .lo_i     (lo_q),
    .data_o   (load_data)
  );

  // The raw read word is not reset, so data is gated by the reset-cleared
  // valid flag; stores and trapped accesses always report zero data.
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (rsp_valid_q && !write_q && !err_q) ? load_data : 32'b0;

`ifdef MISALIGN_TRAP_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;
  import riscv_mem_pkg::*;

  localparam int DEPTH = 64;
  localparam int MEMB  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_memory_stage #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [MEMB];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference: applies one accepted request and queues the
  // response it must produce.
  task automatic model_accept(input bit w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
    int unsigned ua;
    int unsigned size;
    int unsigned base;
    bit          mis;
    logic [31:0] v;
    exp_t        e;
    ua   = a;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (ua % size) != 0;
`endif
    base = (ua - (ua % size)) % MEMB;
    v    = 32'b0;
    if (!mis) begin
      if (w) begin
        for (int i = 0; i < int'(size); i++) ref_mem[base + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < int'(size); i++) v[8*i +: 8] = ref_mem[base + i];
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      end
    end
    e.data = (w || mis) ? 32'b0 : v;
    e.err  = mis;
    exp_q.push_back(e);
  endtask

  // One clock cycle: check outputs, drive inputs, check req_ready, then
  // advance the reference at the rising edge.
  task automatic step(input bit rv, input bit w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit rr);
    bit exp_ready;
    exp_t e;
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("rsp_rdata", rsp_rdata, exp_q[0].data);
      check_eq("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
    end
    req_valid  = rv;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = rr;
    #1;
    exp_ready = (exp_q.size() == 0) || rr;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (rr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_rsp++;
      $display("[TB] rsp %0d consumed data=%h err=%0b", n_rsp, e.data, e.err);
    end
    if (rv && exp_ready) model_accept(w, f3, a, wd);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'b000, 32'b0, 32'b0, 1'b1);
  endtask

  // Called right after a step that accepted a request: the response must
  // already be visible in the following cycle.
  task automatic expect_rsp(input string tag, input logic [31:0] d, input logic e);
    #1;
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_data"}, rsp_rdata, d);
    check_eq({tag, "_err"}, 32'(rsp_err), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;

    // Give every word a defined value
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, F3_W, 32'(i * 4), $urandom, 1'b1);

    // Store word then load it
    step(1'b1, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
    expect_rsp("sw_lw", 32'hDEADBEEF, 1'b0);

    // Byte store into a known word
    step(1'b1, 1'b1, F3_W, 32'h10, 32'h11223344, 1'b1);
    step(1'b1, 1'b1, F3_B, 32'h13, 32'h00000080, 1'b1);
    step(1'b1, 1'b0, F3_B, 32'h13, 32'h0, 1'b1);
    expect_rsp("lb", 32'hFFFFFF80, 1'b0);
    step(1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 1'b1);
    expect_rsp("lbu", 32'h00000080, 1'b0);
    step(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
    expect_rsp("lw_after_sb", 32'h80223344, 1'b0);

    // Halfword store, signed/unsigned loads and address wrap
    step(1'b1, 1'b1, F3_H, 32'h22, 32'h0000BEEF, 1'b1);
    step(1'b1, 1'b0, F3_H, 32'h22, 32'h0, 1'b1);
    expect_rsp("lh", 32'hFFFFBEEF, 1'b0);
    step(1'b1, 1'b0, F3_HU, 32'h22, 32'h0, 1'b1);
    expect_rsp("lhu", 32'h0000BEEF, 1'b0);
    step(1'b1, 1'b0, F3_H, 32'h22 + 32'(MEMB), 32'h0, 1'b1);
    expect_rsp("lh_wrap", 32'hFFFFBEEF, 1'b0);

    // Stall: response held for 3 cycles, then back-to-back acceptance
    step(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0);
    step(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b1);
    step(1'b1, 1'b0, F3_H, 32'h22, 32'h0, 1'b1);
    expect_rsp("b2b_lh", 32'hFFFFBEEF, 1'b0);

    // Misaligned accesses
    step(1'b1, 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 1'b1);
    step(1'b1, 1'b1, F3_W, 32'h41, 32'h12345678, 1'b1);
`ifdef MISALIGN_TRAP_EN
    expect_rsp("mis_sw", 32'h0, 1'b1);
    step(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 1'b1);
    expect_rsp("mis_word_kept", 32'hCAFEF00D, 1'b0);
    step(1'b1, 1'b0, F3_H, 32'h43, 32'h0, 1'b1);
    expect_rsp("mis_lh", 32'h0, 1'b1);
`else
    expect_rsp("unal_sw", 32'h0, 1'b0);
    step(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 1'b1);
    expect_rsp("unal_word_written", 32'h12345678, 1'b0);
`endif

    // Reset with a response pending
    step(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
    check_eq("pre_rst_rdata", rsp_rdata, 32'h80223344);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst       = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_rdata", rsp_rdata, 32'd0);
    check_eq("mid_rst_err", 32'(rsp_err), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
    expect_rsp("post_rst_lw", 32'h80223344, 1'b0);

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           32'($urandom_range(0, 2 * MEMB - 1)), $urandom, $urandom_range(0, 3) != 0);
    end

    idle();
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_stage.md
# data_memory_stage

Parametrised successor to the single-word memory stage: a single-port, word-organised data memory behind the execute stage of the RISC-V pipeline, serving RV32I loads and stores (byte, halfword and word; signed and unsigned loads) with per-byte write strobes. Requests and responses use valid/ready handshakes, so the stage can be stalled by writeback. Load data returns one cycle after acceptance and is held until consumed.

## Interface
Parameters:
- DEPTH, 1024 — number of 32-bit words; power of two, ≥ 2.
- AW, $clog2(DEPTH) — word-index width, derived; not overridden.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — asynchronous, active-low reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — stage can accept a request.
- req_write  in  1  — 1 = store, 0 = load.
- req_funct3  in  3  — RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr  in  32  — byte address.
- req_wdata  in  32  — store data, LSB-aligned.
- rsp_valid  out  1  — response present.
- rsp_ready  in  1  — consumer takes the response.
- rsp_rdata  out  32  — extended load data; 0 for stores.
- rsp_err  out  1  — misaligned access (only with MISALIGN_TRAP_EN).

## Operation
- Accept when req_valid && req_ready; req_ready = !rsp_valid || rsp_ready (combinational).
- Word index = req_addr[AW+1:2]; upper bits ignored, so the address wraps modulo DEPTH*4.
- Store: byte lanes written on the accept edge. SB writes lane addr[1:0] with wdata[7:0]. SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. SW writes all lanes. Unselected lanes are unchanged.
- Load: the word is read synchronously on the accept edge. LB and LH sign-extend; LBU and LHU zero-extend; LW is passed through.
- Every accepted request, load or store, produces exactly one response.
- Undefined funct3 (011, 110, 111): treated as LW/SW.
- Memory array is not reset; contents after power-up are undefined.

## Timing
- Reset: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. An in-flight response is dropped. A store accepted on the same edge that reset asserts is not guaranteed to land.
- Latency: the response is valid in the cycle after acceptance.
- Response hold: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready is seen high.
- Back-to-back throughput: 1 request per cycle while rsp_ready = 1.
- Simultaneous events: a response consumed and a new request accepted in the same cycle loads the new response; no bubble.
- Read after write: a store accepted in cycle N followed by a load to the same word accepted in cycle N+1 returns the stored data. There is no same-cycle hazard because the array is single-port.
- Stall: rsp_valid = 1 && rsp_ready = 0 forces req_ready = 0. No request is accepted and memory is not written.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0, is misaligned.
  - A misaligned access is accepted normally but performs no memory write.
  - Its response has rsp_err = 1 and rsp_rdata = 0.
- MISALIGN_TRAP_EN undefined:
  - rsp_err is tied to 0.
  - Low address bits are forced aligned: halfword uses addr[1]; word ignores addr[1:0].

## Structure
- Shared package riscv_mem_pkg holds the funct3 constants (F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101) and the byte-lane strobe width.
- One sub-module, mem_load_align: combinational lane select plus sign/zero extension, driven by the registered funct3 and addr[1:0].
- The top holds the array, the strobe generation and the response register.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata = 0xDEADBEEF, rsp_err = 0, one cycle after acceptance.
- SB 0x80 @0x13 over 0x11223344, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80223344.
- SH 0xBEEF @0x22, then LH @0x22 → 0xFFFFBEEF; LHU @0x22 → 0x0000BEEF; address 0x22 + DEPTH*4 returns the same data (wrap).
- Hold rsp_ready = 0 for 3 cycles after a load: req_ready = 0, and rsp_valid/rsp_rdata are stable. Releasing rsp_ready with the next request pending gives back-to-back acceptance.
- With MISALIGN_TRAP_EN: SW 0x12345678 @0x41 → rsp_err = 1 and word 0x40 is unchanged; LH @0x43 → rsp_err = 1, rsp_rdata = 0. Without it: the same SW writes word 0x40.
- Assert rst while rsp_valid = 1 → rsp_valid, rsp_rdata and rsp_err go to 0 immediately. Data stored before reset is still readable afterwards.
